hdmi_timing_ctrl: RTL and testbench
===================================

// Module: hdmi_timing_ctrl
// PURPOSE
//  Programmable video timing sequencer for the HDMI path: generates pixel X/Y, DE, HSync, VSync
//  and line/frame strobes that drive the pixel shader and the three TMDS encoders.
//  Timing is runtime-reconfigurable via shadow registers committed only at frame boundaries.
//  Run/stop sequencing always completes the current frame, so the sink never sees a torn frame.
// PARAMETERS
//  W        12   counter / config field width (max total 4095)
//  H_ACTIVE 640  reset value: active pixels per line
//  H_FP     16   reset value: horizontal front porch
//  H_SYNC   96   reset value: hsync width
//  H_BP     48   reset value: horizontal back porch
//  V_ACTIVE 480  reset value: active lines;  V_FP 10, V_SYNC 2, V_BP 33 likewise
//  HS_POL   1    hsync active level;  VS_POL 1  vsync active level
// PORTS
//  pixclk       in  1   pixel clock, 25MHz at reset timing
//  reset        in  1   synchronous, active-high
//  run          in  1   level: 1=generate video, 0=stop at end of current frame
//  cfg_we       in  1   write strobe, shadow register cfg_addr <= cfg_wdata
//  cfg_addr     in  3   0..7 = H_ACTIVE,H_FP,H_SYNC,H_BP,V_ACTIVE,V_FP,V_SYNC,V_BP
//  cfg_wdata    in  W   field value
//  cfg_commit   in  1   pulse: request shadow->live transfer at next frame boundary
//  cfg_pending  out 1   commit accepted, not yet applied
//  cfg_err      out 1   sticky: last commit rejected (a shadow field ==0); cleared by next good commit
//  active       out 1   1 while in RUN or DRAIN state
//  x, y         out W   current pixel coordinate
//  de           out 1   x<H_ACTIVE && y<V_ACTIVE (live values)
//  hsync, vsync out 1   at programmed polarity
//  line_start   out 1   1-cycle strobe when x==0
//  frame_start  out 1   1-cycle strobe when x==0 && y==0
// BEHAVIOUR
//  - All outputs registered, mutually aligned (x,y,de,syncs,strobes describe same pixel).
//  - Reset: state IDLE; live+shadow = parameter defaults; x=y=0; de=line_start=frame_start=0;
//    hsync=~HS_POL, vsync=~VS_POL; cfg_pending=cfg_err=active=0. Reset mid-frame aborts at once.
//  - h_total = H_ACTIVE+H_FP+H_SYNC+H_BP (W-bit; overflow is user error, unchecked); v_total likewise.
//  - hsync active for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync for y in [V_ACTIVE+V_FP, +V_SYNC).
//  - x wraps h_total-1 -> 0 and y increments; y wraps v_total-1 -> 0 on same cycle x wraps.
//  - States: IDLE -(run=1)-> RUN -(run=0)-> DRAIN -(last pixel of frame)-> IDLE;
//    DRAIN -(run=1 again)-> RUN (no gap). IDLE outputs as reset, except live/shadow/cfg_* kept.
//  - Cycle after IDLE->RUN: x=0,y=0,de=1,line_start=frame_start=1.
//  - Frame boundary = cycle where x==h_total-1 && y==v_total-1, or the IDLE->RUN transition.
//  - cfg_commit: if any shadow field ==0 -> cfg_err=1, no pending. Else cfg_pending=1, cfg_err=0.
//    Commit while pending: re-validated, stays pending. At frame boundary pending: live<=shadow,
//    cfg_pending=0; new timing takes effect from next x=0,y=0 pixel. IDLE+commit: applied on next run.
//  - cfg_we allowed anytime; only alters shadow, never live mid-frame. cfg_we and cfg_commit same
//    cycle: commit validates/uses the value being written.
//  - cfg_commit on the boundary cycle itself: applied at that boundary.
// CONFIGURATION
//  HDMI_TIMING_FRAMECNT_EN defined: adds output frame_count [15:0], reset 0, incremented on each
//   frame_start, wraps 0xFFFF->0, held in IDLE. Undefined: port and counter absent, no other change.
// TESTING
//  1 reset, run=1 defaults -> h_total 800, v_total 525; frame_start period 420000 cycles; de high
//    307200 cycles/frame; hsync high x=656..751; vsync high y=490..491.
//  2 run=0 at y=100 -> active until x=799,y=524 then IDLE, de=0, hsync/vsync inactive; run=1 ->
//    next cycle x=0,y=0,frame_start=1.
//  3 write H_ACTIVE=320, H_BP=8, commit mid-frame -> cfg_pending=1, old 800-pixel lines to frame end,
//    then h_total=440, pending=0, de 320 cycles/line.
//  4 write V_SYNC=0, commit -> cfg_err=1, pending=0, timing unchanged; write 2, commit -> err=0.
//  5 reset asserted at x=300,y=200 while pending -> all outputs at reset values, live=defaults.
//  6 HDMI_TIMING_FRAMECNT_EN: 3 frames -> frame_count=3; force 0xFFFF -> next frame 0.

Source files
------------

// File: rtl/hdmi_timing_ctrl.sv
// Programmable video timing sequencer: pixel X/Y, DE, syncs and line/frame strobes, with shadow
// timing registers committed at frame boundaries. Define HDMI_TIMING_FRAMECNT_EN to add frame_count_o.
module hdmi_timing_ctrl #(
  parameter int   W        = 12,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic         pixclk_i,
  input  logic         reset_i,
  input  logic         run_i,
  input  logic         cfg_we_i,
  input  logic [2:0]   cfg_addr_i,
  input  logic [W-1:0] cfg_wdata_i,
  input  logic         cfg_commit_i,
  output logic         cfg_pending_o,
  output logic         cfg_err_o,
  output logic         active_o,
  output logic [W-1:0] x_o,
  output logic [W-1:0] y_o,
  output logic         de_o,
  output logic         hsync_o,
  output logic         vsync_o,
  output logic         line_start_o,
  output logic         frame_start_o
`ifdef HDMI_TIMING_FRAMECNT_EN
  ,
  output logic [15:0]  frame_count_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  localparam int F_HA  = 0;
  localparam int F_HFP = 1;
  localparam int F_HS  = 2;
  localparam int F_HBP = 3;
  localparam int F_VA  = 4;
  localparam int F_VFP = 5;
  localparam int F_VS  = 6;
  localparam int F_VBP = 7;

  localparam logic [W-1:0] CFG_RESET [8] = '{
    W'(H_ACTIVE), W'(H_FP), W'(H_SYNC), W'(H_BP),
    W'(V_ACTIVE), W'(V_FP), W'(V_SYNC), W'(V_BP)
  };

  state_e       state_q, state_d;
  logic [W-1:0] shadow_q [8];
  logic [W-1:0] shadow_d [8];
  logic [W-1:0] live_q   [8];
  logic [W-1:0] live_d   [8];
  logic         pending_q, pending_d;
  logic         err_q, err_d;
  logic         active_q;
  logic [W-1:0] x_q, x_d, y_q, y_d;
  logic         de_q, de_d;
  logic         hsync_q, hsync_d;
  logic         vsync_q, vsync_d;
  logic         ls_q, ls_d;
  logic         fs_q, fs_d;

  logic [W-1:0] h_total, v_total;
  logic         last_pix;
  logic         boundary;
  logic         commit_ok;
  logic         apply;
  logic         go;
  logic [W-1:0] hs_start, hs_end, vs_start, vs_end;

  // Shadow view including this cycle's write, so a same-cycle commit validates the new value.
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we_i) shadow_d[cfg_addr_i] = cfg_wdata_i;
  end

  always_comb begin
    commit_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (shadow_d[i] == '0) commit_ok = 1'b0;
    end
  end

  assign h_total  = live_q[F_HA] + live_q[F_HFP] + live_q[F_HS] + live_q[F_HBP];
  assign v_total  = live_q[F_VA] + live_q[F_VFP] + live_q[F_VS] + live_q[F_VBP];
  assign last_pix = (x_q == h_total - W'(1)) && (y_q == v_total - W'(1));
  assign boundary = (state_q == ST_IDLE) ? run_i : last_pix;
  assign apply    = boundary && (cfg_commit_i ? commit_ok : pending_q);

  // A pending commit takes the shadow as it stood; a commit on this very cycle takes the write too.
  always_comb begin
    live_d = live_q;
    if (apply) live_d = cfg_commit_i ? shadow_d : shadow_q;
  end

  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
    if (cfg_commit_i) begin
      err_d     = !commit_ok;
      pending_d = commit_ok && !apply;
    end else if (apply) begin
      pending_d = 1'b0;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (run_i) state_d = ST_RUN;
      ST_RUN:   if (!run_i) state_d = last_pix ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (run_i)         state_d = ST_RUN;
        else if (last_pix) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Coordinates of the pixel presented next cycle; IDLE shows the origin with everything inactive.
  always_comb begin
    go  = (state_d != ST_IDLE);
    x_d = '0;
    y_d = '0;
    if (go && state_q != ST_IDLE) begin
      if (x_q == h_total - W'(1)) begin
        y_d = (y_q == v_total - W'(1)) ? '0 : y_q + W'(1);
      end else begin
        x_d = x_q + W'(1);
        y_d = y_q;
      end
    end
  end

  // Decode against live_d so the first pixel after a boundary already uses the new timing.
  assign hs_start = live_d[F_HA] + live_d[F_HFP];
  assign hs_end   = hs_start + live_d[F_HS];
  assign vs_start = live_d[F_VA] + live_d[F_VFP];
  assign vs_end   = vs_start + live_d[F_VS];

  always_comb begin
    de_d    = go && (x_d < live_d[F_HA]) && (y_d < live_d[F_VA]);
    hsync_d = (go && x_d >= hs_start && x_d < hs_end) ? HS_POL : ~HS_POL;
    vsync_d = (go && y_d >= vs_start && y_d < vs_end) ? VS_POL : ~VS_POL;
    ls_d    = go && (x_d == '0);
    fs_d    = ls_d && (y_d == '0);
  end

  // NOTE: the eight-entry shadow/live files are reset because their defaults are the power-up timing.
  always_ff @(posedge pixclk_i) begin
    if (reset_i) begin
      shadow_q <= CFG_RESET;
      live_q   <= CFG_RESET;
    end else begin
      shadow_q <= shadow_d;
      live_q   <= live_d;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge pixclk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      active_q  <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      de_q      <= 1'b0;
      hsync_q   <= ~HS_POL;
      vsync_q   <= ~VS_POL;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      active_q  <= go;
      x_q       <= x_d;
      y_q       <= y_d;
      de_q      <= de_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      ls_q      <= ls_d;
      fs_q      <= fs_d;
    end
  end

  assign cfg_pending_o = pending_q;
  assign cfg_err_o     = err_q;
  assign active_o      = active_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign de_o          = de_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign line_start_o  = ls_q;
  assign frame_start_o = fs_q;

`ifdef HDMI_TIMING_FRAMECNT_EN
  logic [15:0] frame_count_q;

  always_ff @(posedge pixclk_i) begin
    if (reset_i)   frame_count_q <= '0;
    else if (fs_d) frame_count_q <= frame_count_q + 16'd1;
  end

  assign frame_count_o = frame_count_q;
`endif

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Directed bench for hdmi_timing_ctrl using a shrunken raster (16x10 default, 8x6 active)
// so full frames stay short; VS_POL=0 exercises the inverted sync polarity.
module tb_hdmi_timing_ctrl;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset, run, cfg_we, cfg_commit;
  logic [2:0]   cfg_addr;
  logic [W-1:0] cfg_wdata;
  logic         cfg_pending_o, cfg_err_o, active_o;
  logic [W-1:0] x_o, y_o;
  logic         de_o, hsync_o, vsync_o, line_start_o, frame_start_o;
`ifdef HDMI_TIMING_FRAMECNT_EN
  logic [15:0]  frame_count_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hdmi_timing_ctrl #(
    .W(W), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut (
    .pixclk_i(clk), .reset_i(reset), .run_i(run),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata), .cfg_commit_i(cfg_commit),
    .cfg_pending_o(cfg_pending_o), .cfg_err_o(cfg_err_o), .active_o(active_o),
    .x_o(x_o), .y_o(y_o), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .line_start_o(line_start_o), .frame_start_o(frame_start_o)
`ifdef HDMI_TIMING_FRAMECNT_EN
    , .frame_count_o(frame_count_o)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input int d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = W'(d);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  task automatic wait_fs(input int limit, output int n);
    n = 0;
    while (frame_start_o !== 1'b1 && n < limit) begin step(); n++; end
    if (frame_start_o !== 1'b1) n = -1;
  endtask

  // Walks one whole frame from pixel (0,0), comparing every output to the raster formula.
  task automatic scan_frame(input int ht, vt, ha, hfp, hs, va, vfp, vs,
                            output int bad, output int de_cnt);
    int ex, ey;
    logic e_de, e_hs, e_vs, e_ls, e_fs;
    bad = 0; de_cnt = 0;
    for (int i = 0; i < ht * vt; i++) begin
      ex   = i % ht;
      ey   = i / ht;
      e_de = (ex < ha) && (ey < va);
      e_hs = (ex >= ha + hfp) && (ex < ha + hfp + hs);
      e_vs = !((ey >= va + vfp) && (ey < va + vfp + vs));
      e_ls = (ex == 0);
      e_fs = (ex == 0) && (ey == 0);
      if ({x_o, y_o, de_o, hsync_o, vsync_o, line_start_o, frame_start_o, active_o} !==
          {W'(ex), W'(ey), e_de, e_hs, e_vs, e_ls, e_fs, 1'b1}) bad++;
      if (de_o === 1'b1) de_cnt++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) step();
    reset = 1'b0;
    checks++; if (x_o !== '0) begin failures++; $display("FAIL reset_x got=%0d exp=0", x_o); end
    checks++; if (y_o !== '0) begin failures++; $display("FAIL reset_y got=%0d exp=0", y_o); end
    checks++; if (de_o !== 1'b0) begin failures++; $display("FAIL reset_de got=%b exp=0", de_o); end
    checks++; if (hsync_o !== 1'b0) begin failures++; $display("FAIL reset_hsync got=%b exp=0", hsync_o); end
    checks++; if (vsync_o !== 1'b1) begin failures++; $display("FAIL reset_vsync got=%b exp=1", vsync_o); end
    checks++; if ({line_start_o, frame_start_o} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", line_start_o, frame_start_o); end
    checks++; if ({cfg_pending_o, cfg_err_o, active_o} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b%b%b exp=000", cfg_pending_o, cfg_err_o, active_o); end
    step();
    checks++; if ({active_o, de_o, x_o} !== {2'b00, W'(0)}) begin failures++; $display("FAIL idle_hold active=%b de=%b x=%0d", active_o, de_o, x_o); end
  endtask

  task automatic test_defaults();
    int bad, dc;
    run = 1'b1;
    step();
    checks++; if ({x_o, y_o} !== {W'(0), W'(0)}) begin failures++; $display("FAIL start_xy got=%0d,%0d exp=0,0", x_o, y_o); end
    checks++; if ({de_o, line_start_o, frame_start_o, active_o} !== 4'b1111) begin failures++; $display("FAIL start_flags got=%b%b%b%b exp=1111", de_o, line_start_o, frame_start_o, active_o); end
    scan_frame(16, 10, 8, 2, 3, 6, 1, 2, bad, dc);
    checks++; if (bad != 0) begin failures++; $display("FAIL default_frame bad_pixels=%0d exp=0", bad); end
    checks++; if (dc != 48) begin failures++; $display("FAIL default_de_count got=%0d exp=48", dc); end
    checks++; if (frame_start_o !== 1'b1 || x_o !== '0 || y_o !== '0) begin failures++; $display("FAIL fs_period fs=%b x=%0d y=%0d exp fs=1 at 0,0", frame_start_o, x_o, y_o); end
  endtask

  task automatic test_drain();
    int n; logic [W-1:0] lx, ly;
    repeat (48) step();
    run = 1'b0;
    step();
    checks++; if ({active_o, x_o, y_o} !== {1'b1, W'(1), W'(3)}) begin failures++; $display("FAIL drain_cont active=%b x=%0d y=%0d exp 1,1,3", active_o, x_o, y_o); end
    n = 0; lx = '0; ly = '0;
    while (active_o === 1'b1 && n < 400) begin lx = x_o; ly = y_o; step(); n++; end
    checks++; if (n != 111) begin failures++; $display("FAIL drain_len got=%0d exp=111", n); end
    checks++; if ({lx, ly} !== {W'(15), W'(9)}) begin failures++; $display("FAIL drain_last got=%0d,%0d exp=15,9", lx, ly); end
    checks++; if ({de_o, hsync_o, vsync_o, frame_start_o, active_o} !== 5'b00100) begin failures++; $display("FAIL drain_idle got=%b%b%b%b%b exp=00100", de_o, hsync_o, vsync_o, frame_start_o, active_o); end
    run = 1'b1;
    step();
    checks++; if ({x_o, y_o, frame_start_o, active_o} !== {W'(0), W'(0), 2'b11}) begin failures++; $display("FAIL restart x=%0d y=%0d fs=%b act=%b", x_o, y_o, frame_start_o, active_o); end
  endtask

  task automatic test_back_to_back();
    int n, inact;
    run = 1'b0;
    repeat (5) step();
    run = 1'b1;
    n = 0; inact = 0;
    while (frame_start_o !== 1'b1 && n < 400) begin
      if (active_o !== 1'b1) inact++;
      step(); n++;
    end
    checks++; if (n != 155) begin failures++; $display("FAIL b2b_len got=%0d exp=155", n); end
    checks++; if (inact != 0) begin failures++; $display("FAIL b2b_gap inactive_cycles=%0d exp=0", inact); end
  endtask

  task automatic test_commit();
    int n, bad, dc;
    repeat (20) step();
    cfg_write(3'd0, 4);
    cfg_write(3'd3, 1);
    commit();
    checks++; if ({cfg_pending_o, cfg_err_o} !== 2'b10) begin failures++; $display("FAIL commit_pending got=%b%b exp=10", cfg_pending_o, cfg_err_o); end
    checks++; if ({x_o, y_o} !== {W'(7), W'(1)}) begin failures++; $display("FAIL commit_oldtiming got=%0d,%0d exp=7,1", x_o, y_o); end
    wait_fs(400, n);
    checks++; if (n != 137) begin failures++; $display("FAIL commit_frame_end got=%0d exp=137", n); end
    checks++; if (cfg_pending_o !== 1'b0) begin failures++; $display("FAIL commit_applied pending=%b exp=0", cfg_pending_o); end
    scan_frame(10, 10, 4, 2, 3, 6, 1, 2, bad, dc);
    checks++; if (bad != 0) begin failures++; $display("FAIL new_frame bad_pixels=%0d exp=0", bad); end
    checks++; if (dc != 24) begin failures++; $display("FAIL new_de_count got=%0d exp=24", dc); end
  endtask

  task automatic test_commit_on_boundary();
    int bad, dc;
    repeat (98) step();
    cfg_write(3'd3, 3);
    checks++; if ({x_o, y_o} !== {W'(9), W'(9)}) begin failures++; $display("FAIL bnd_pos got=%0d,%0d exp=9,9", x_o, y_o); end
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = W'(8); cfg_commit = 1'b1;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    checks++; if ({frame_start_o, cfg_pending_o, cfg_err_o} !== 3'b100) begin failures++; $display("FAIL bnd_commit fs=%b pend=%b err=%b exp 100", frame_start_o, cfg_pending_o, cfg_err_o); end
    scan_frame(16, 10, 8, 2, 3, 6, 1, 2, bad, dc);
    checks++; if (bad != 0 || dc != 48) begin failures++; $display("FAIL bnd_frame bad=%0d de=%0d exp 0,48", bad, dc); end
  endtask

  task automatic test_cfg_err();
    int n, bad, dc;
    cfg_write(3'd6, 0);
    commit();
    checks++; if ({cfg_err_o, cfg_pending_o} !== 2'b10) begin failures++; $display("FAIL err_set got err=%b pend=%b exp 1,0", cfg_err_o, cfg_pending_o); end
    wait_fs(400, n);
    checks++; if (n != 158) begin failures++; $display("FAIL err_frame_end got=%0d exp=158", n); end
    scan_frame(16, 10, 8, 2, 3, 6, 1, 2, bad, dc);
    checks++; if (bad != 0 || dc != 48) begin failures++; $display("FAIL err_timing bad=%0d de=%0d exp 0,48", bad, dc); end
    cfg_we = 1'b1; cfg_addr = 3'd6; cfg_wdata = W'(2); cfg_commit = 1'b1;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    checks++; if ({cfg_err_o, cfg_pending_o} !== 2'b01) begin failures++; $display("FAIL err_clear got err=%b pend=%b exp 0,1", cfg_err_o, cfg_pending_o); end
  endtask

  task automatic test_reset_mid();
    int bad, dc;
    cfg_write(3'd0, 4);
    commit();
    checks++; if ({cfg_pending_o, cfg_err_o} !== 2'b10) begin failures++; $display("FAIL recommit got pend=%b err=%b exp 1,0", cfg_pending_o, cfg_err_o); end
    repeat (66) step();
    checks++; if ({x_o, y_o} !== {W'(5), W'(4)}) begin failures++; $display("FAIL mid_pos got=%0d,%0d exp=5,4", x_o, y_o); end
    run = 1'b0; reset = 1'b1;
    step();
    checks++; if ({x_o, y_o} !== {W'(0), W'(0)}) begin failures++; $display("FAIL rst_mid_xy got=%0d,%0d exp=0,0", x_o, y_o); end
    checks++; if ({de_o, hsync_o, vsync_o, line_start_o, frame_start_o} !== 5'b00100) begin failures++; $display("FAIL rst_mid_video got=%b%b%b%b%b exp=00100", de_o, hsync_o, vsync_o, line_start_o, frame_start_o); end
    checks++; if ({cfg_pending_o, cfg_err_o, active_o} !== 3'b000) begin failures++; $display("FAIL rst_mid_status got=%b%b%b exp=000", cfg_pending_o, cfg_err_o, active_o); end
    reset = 1'b0; run = 1'b1;
    step();
    scan_frame(16, 10, 8, 2, 3, 6, 1, 2, bad, dc);
    checks++; if (bad != 0 || dc != 48) begin failures++; $display("FAIL rst_live_default bad=%0d de=%0d exp 0,48", bad, dc); end
  endtask

  task automatic test_idle_commit();
    int n, bad, dc;
    run = 1'b0;
    n = 0;
    while (active_o === 1'b1 && n < 400) begin step(); n++; end
    checks++; if (n != 160) begin failures++; $display("FAIL idle_stop got=%0d exp=160", n); end
    cfg_write(3'd0, 4);
    cfg_write(3'd3, 1);
    commit();
    checks++; if ({cfg_pending_o, active_o, de_o, x_o} !== {3'b100, W'(0)}) begin failures++; $display("FAIL idle_pend pend=%b act=%b de=%b x=%0d", cfg_pending_o, active_o, de_o, x_o); end
    run = 1'b1;
    step();
    checks++; if ({cfg_pending_o, frame_start_o} !== 2'b01) begin failures++; $display("FAIL idle_apply pend=%b fs=%b exp 0,1", cfg_pending_o, frame_start_o); end
    scan_frame(10, 10, 4, 2, 3, 6, 1, 2, bad, dc);
    checks++; if (bad != 0 || dc != 24) begin failures++; $display("FAIL idle_frame bad=%0d de=%0d exp 0,24", bad, dc); end
  endtask

`ifdef HDMI_TIMING_FRAMECNT_EN
  task automatic test_frame_count();
    int n;
    run = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0; run = 1'b1;
    step();
    repeat (320) step();
    checks++; if ({frame_start_o, frame_count_o} !== {1'b1, 16'd3}) begin failures++; $display("FAIL fcnt_three fs=%b cnt=%0d exp 1,3", frame_start_o, frame_count_o); end
    step();
    force dut.frame_count_q = 16'hFFFF;
    #1;
    release dut.frame_count_q;
    wait_fs(400, n);
    checks++; if (frame_count_o !== 16'd0 || n < 0) begin failures++; $display("FAIL fcnt_wrap cnt=%0h n=%0d exp 0", frame_count_o, n); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_defaults();
    test_drain();
    test_back_to_back();
    test_commit();
    test_commit_on_boundary();
    test_cfg_err();
    test_reset_mid();
    test_idle_commit();
`ifdef HDMI_TIMING_FRAMECNT_EN
    test_frame_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
